// File: rtl/pea_host_sequencer.sv
// pea_host_sequencer: feeds one PEA command and its data words into the core input FIFOs, then drains result/status tokens onto one response stream.
// Latency: command token written the cycle after acceptance; 2 cycles from a non-zero output-FIFO population to rsp_valid.
// Backpressure: zero free space stalls the pushes without loss; rsp_valid/rsp_data hold until rsp_ready, and no FIFO read is issued while a response is pending.
module pea_host_sequencer #(
    parameter int WORD_SIZE      = 16,
    parameter int BUFFER_SIZE    = 1024,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int L             = $clog2(BUFFER_SIZE)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [WORD_SIZE-1:0]   req_cmd,
    input  logic                   din_valid,
    output logic                   din_ready,
    input  logic [WORD_SIZE-1:0]   din,
    output logic                   cmd_wr_en,
    output logic [WORD_SIZE-1:0]   cmd_out,
    input  logic [L-1:0]           cmd_free_space,
    output logic                   data_wr_en,
    output logic [WORD_SIZE-1:0]   data_out,
    input  logic [L-1:0]           data_free_space,
    output logic                   result_rd_en,
    input  logic [2*WORD_SIZE-1:0] result_in,
    input  logic [L-1:0]           result_pop,
    output logic                   status_rd_en,
    input  logic [2*WORD_SIZE-1:0] status_in,
    input  logic [L-1:0]           status_pop,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [2*WORD_SIZE-1:0] rsp_data,
    output logic                   rsp_is_status,
    output logic                   busy
);

    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] OP_STP = 8'd1;
    localparam logic [7:0] OP_EVP = 8'd2;
    localparam logic [7:0] OP_EVB = 8'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PUSH_CMD,
        S_PUSH_DATA,
        S_COLLECT
    } state_t;

    state_t                 state_q, state_d;
    logic [WORD_SIZE-1:0]   cmd_q, cmd_d;
    logic [5:0]             n_data_q, n_data_d;
    logic [4:0]             n_res_q, n_res_d;
    logic                   rd_pend_q, rd_pend_d;   // a FIFO read was issued last cycle
    logic                   rd_src_q, rd_src_d;     // 1 = that read targeted the status FIFO
    logic                   rsp_valid_q, rsp_valid_d;
    logic [2*WORD_SIZE-1:0] rsp_data_q, rsp_data_d;
    logic                   rsp_is_status_q, rsp_is_status_d;
    logic [WDW-1:0]         wdog_q, wdog_d;

    assign cmd_out       = cmd_q;
    assign data_out      = din;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_is_status = rsp_is_status_q;
    assign busy          = (state_q != S_IDLE);

    // State and datapath registers; reset abandons any command in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            cmd_q           <= '0;
            n_data_q        <= '0;
            n_res_q         <= '0;
            rd_pend_q       <= 1'b0;
            rd_src_q        <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_data_q      <= '0;
            rsp_is_status_q <= 1'b0;
            wdog_q          <= '0;
        end else begin
            state_q         <= state_d;
            cmd_q           <= cmd_d;
            n_data_q        <= n_data_d;
            n_res_q         <= n_res_d;
            rd_pend_q       <= rd_pend_d;
            rd_src_q        <= rd_src_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_data_q      <= rsp_data_d;
            rsp_is_status_q <= rsp_is_status_d;
            wdog_q          <= wdog_d;
        end
    end

    // Next-state, FIFO strobes and response capture.
    always_comb begin
        state_d         = state_q;
        cmd_d           = cmd_q;
        n_data_d        = n_data_q;
        n_res_d         = n_res_q;
        rd_pend_d       = rd_pend_q;
        rd_src_d        = rd_src_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_data_d      = rsp_data_q;
        rsp_is_status_d = rsp_is_status_q;
        wdog_d          = wdog_q;
        req_ready       = 1'b0;
        din_ready       = 1'b0;
        cmd_wr_en       = 1'b0;
        data_wr_en      = 1'b0;
        result_rd_en    = 1'b0;
        status_rd_en    = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    cmd_d   = req_cmd;
                    state_d = S_PUSH_CMD;
                    // Unknown opcodes carry no data and expect no results.
                    case (req_cmd[15:8])
                        OP_STP: begin
                            n_data_d = 6'(req_cmd[4:0]) + 6'd1;
                            n_res_d  = '0;
                        end
                        OP_EVP, OP_EVB: begin
                            n_data_d = 6'(req_cmd[4:0]);
                            n_res_d  = req_cmd[4:0];
                        end
                        default: begin
                            n_data_d = '0;
                            n_res_d  = '0;
                        end
                    endcase
                end
            end

            S_PUSH_CMD: begin
                if (cmd_free_space != '0) begin
                    cmd_wr_en = 1'b1;
                    if (n_data_q != '0) begin
                        state_d = S_PUSH_DATA;
                    end else begin
                        state_d = S_COLLECT;
                        wdog_d  = '0;
                    end
                end
            end

            S_PUSH_DATA: begin
                din_ready = (data_free_space != '0);
                if (din_valid && din_ready) begin
                    data_wr_en = 1'b1;
                    n_data_d   = n_data_q - 6'd1;
                    if (n_data_q == 6'd1) begin
                        state_d = S_COLLECT;
                        wdog_d  = '0;
                    end
                end
            end

            S_COLLECT: begin
                if (rd_pend_q) begin
                    // Token from last cycle's read is now on the FIFO output.
                    rd_pend_d       = 1'b0;
                    rsp_valid_d     = 1'b1;
                    rsp_data_d      = rd_src_q ? status_in : result_in;
                    rsp_is_status_d = rd_src_q;
                end else if (rsp_valid_q) begin
                    if (rsp_ready) begin
                        rsp_valid_d = 1'b0;
                        // A status (or watchdog) token closes the command; leftover results are dropped.
                        if (rsp_is_status_q) begin
                            state_d = S_IDLE;
                            n_res_d = '0;
                        end
                    end
                end else if (n_res_q != '0 && result_pop != '0) begin
                    result_rd_en = 1'b1;
                    rd_pend_d    = 1'b1;
                    rd_src_d     = 1'b0;
                    n_res_d      = n_res_q - 5'd1;
                    wdog_d       = '0;
                end else if (status_pop != '0) begin
                    status_rd_en = 1'b1;
                    rd_pend_d    = 1'b1;
                    rd_src_d     = 1'b1;
                    wdog_d       = '0;
                end else if (wdog_q == WDW'(TIMEOUT_CYCLES - 1)) begin
                    // Core went silent: synthesize an abort status token.
                    rsp_valid_d     = 1'b1;
                    rsp_data_d      = '1;
                    rsp_is_status_d = 1'b1;
                    wdog_d          = '0;
                end else begin
                    wdog_d = wdog_q + WDW'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pea_host_sequencer.sv
module tb_pea_host_sequencer;

    localparam int L = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_cmd = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [15:0] din = '0;
    logic        cmd_wr_en;
    logic [15:0] cmd_out;
    logic [L-1:0] cmd_free_space = 10'd100;
    logic        data_wr_en;
    logic [15:0] data_out;
    logic [L-1:0] data_free_space = 10'd100;
    logic        result_rd_en;
    logic [31:0] result_in = '0;
    logic [L-1:0] result_pop;
    logic        status_rd_en;
    logic [31:0] status_in = '0;
    logic [L-1:0] status_pop;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_is_status;
    logic        busy;

    int total = 0;
    int bad   = 0;

    pea_host_sequencer #(
        .WORD_SIZE      (16),
        .BUFFER_SIZE    (1024),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_cmd         (req_cmd),
        .din_valid       (din_valid),
        .din_ready       (din_ready),
        .din             (din),
        .cmd_wr_en       (cmd_wr_en),
        .cmd_out         (cmd_out),
        .cmd_free_space  (cmd_free_space),
        .data_wr_en      (data_wr_en),
        .data_out        (data_out),
        .data_free_space (data_free_space),
        .result_rd_en    (result_rd_en),
        .result_in       (result_in),
        .result_pop      (result_pop),
        .status_rd_en    (status_rd_en),
        .status_in       (status_in),
        .status_pop      (status_pop),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .rsp_is_status   (rsp_is_status),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Output FIFO models: tokens appear on the cycle after the read strobe.
    logic [31:0] res_mem [0:15];
    logic [31:0] sts_mem [0:15];
    int res_wp = 0, res_rp = 0, sts_wp = 0, sts_rp = 0;
    assign result_pop = L'(res_wp - res_rp);
    assign status_pop = L'(sts_wp - sts_rp);

    always @(posedge clk) begin
        if (result_rd_en) begin
            result_in <= res_mem[res_rp & 15];
            res_rp    <= res_rp + 1;
        end
        if (status_rd_en) begin
            status_in <= sts_mem[sts_rp & 15];
            sts_rp    <= sts_rp + 1;
        end
    end

    // Logs of every input-FIFO write and read strobe.
    logic [15:0] clog [0:63];
    logic [15:0] dlog [0:63];
    int ccnt = 0, dcnt = 0, rrd_cnt = 0, srd_cnt = 0;

    always @(negedge clk) begin
        if (cmd_wr_en) begin
            clog[ccnt & 63] = cmd_out;
            ccnt = ccnt + 1;
        end
        if (data_wr_en) begin
            dlog[dcnt & 63] = data_out;
            dcnt = dcnt + 1;
        end
        if (result_rd_en) rrd_cnt = rrd_cnt + 1;
        if (status_rd_en) srd_cnt = srd_cnt + 1;
    end

    task automatic push_result(input logic [31:0] v);
        res_mem[res_wp & 15] = v;
        res_wp = res_wp + 1;
    endtask

    task automatic push_status(input logic [31:0] v);
        sts_mem[sts_wp & 15] = v;
        sts_wp = sts_wp + 1;
    endtask

    task automatic send_req(input logic [15:0] c);
        req_cmd   = c;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        int k;
        din       = w;
        din_valid = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!din_ready && k < 200);
        total++;
        if (!din_ready) begin
            bad++;
            $display("FAIL send_word timeout: din_ready=%b required 1 for word %h", din_ready, w);
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    // Waits for a response, optionally holds rsp_ready low for 'hold' cycles, then accepts it.
    task automatic get_rsp(input int hold, output logic [31:0] d, output logic st,
                           output bit ok, output bit stable);
        int k;
        k = 0; ok = 0; stable = 1; d = 'x; st = 1'bx;
        while (k < 300 && !ok) begin
            @(negedge clk);
            k++;
            if (rsp_valid) ok = 1;
        end
        if (ok) begin
            d  = rsp_data;
            st = rsp_is_status;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (!rsp_valid || rsp_data !== d || result_rd_en || status_rd_en) stable = 0;
            end
            @(posedge clk);
            #1 rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        #2;
        total++; if (busy !== 1'b0)          begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
        total++; if (req_ready !== 1'b1)     begin bad++; $display("FAIL reset req_ready: got %b want 1", req_ready); end
        total++; if (rsp_valid !== 1'b0)     begin bad++; $display("FAIL reset rsp_valid: got %b want 0", rsp_valid); end
        total++; if (rsp_data !== 32'h0)     begin bad++; $display("FAIL reset rsp_data: got %h want 0", rsp_data); end
        total++; if (rsp_is_status !== 1'b0) begin bad++; $display("FAIL reset rsp_is_status: got %b want 0", rsp_is_status); end
        total++; if (cmd_out !== 16'h0)      begin bad++; $display("FAIL reset cmd_out: got %h want 0", cmd_out); end
        total++;
        if ({cmd_wr_en, data_wr_en, result_rd_en, status_rd_en} !== 4'b0) begin
            bad++;
            $display("FAIL reset enables: got %b want 0000", {cmd_wr_en, data_wr_en, result_rd_en, status_rd_en});
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_stp;
        int c0, d0;
        logic [31:0] d; logic st; bit ok, stable;
        c0 = ccnt; d0 = dcnt;
        send_req(16'h0123);
        for (int i = 1; i <= 4; i++) send_word(16'(i));
        push_status(32'h0);
        get_rsp(0, d, st, ok, stable);
        total++; if (ccnt - c0 !== 1)        begin bad++; $display("FAIL stp cmd count: got %0d want 1", ccnt - c0); end
        total++; if (clog[c0 & 63] !== 16'h0123) begin bad++; $display("FAIL stp cmd token: got %h want 0123", clog[c0 & 63]); end
        total++; if (dcnt - d0 !== 4)        begin bad++; $display("FAIL stp data count: got %0d want 4", dcnt - d0); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (dlog[(d0 + i) & 63] !== 16'(i + 1)) begin
                bad++; $display("FAIL stp data[%0d]: got %h want %h", i, dlog[(d0 + i) & 63], 16'(i + 1));
            end
        end
        total++; if (!ok)                    begin bad++; $display("FAIL stp rsp timeout: got none want status"); end
        total++; if (d !== 32'h0 || st !== 1'b1) begin bad++; $display("FAIL stp rsp: got %h/%b want 00000000/1", d, st); end
        total++; if (busy !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL stp idle: got busy=%b rdy=%b want 0/1", busy, req_ready); end
    endtask

    task automatic test_evp;
        int r0;
        logic [31:0] d; logic st; bit ok, stable;
        logic [31:0] exp_d [0:3];
        logic        exp_s [0:3];
        exp_d[0] = 32'd10; exp_d[1] = 32'd20; exp_d[2] = 32'd30; exp_d[3] = 32'd0;
        exp_s[0] = 1'b0;   exp_s[1] = 1'b0;   exp_s[2] = 1'b0;   exp_s[3] = 1'b1;
        r0 = rrd_cnt;
        send_req(16'h0223);
        send_word(16'd5); send_word(16'd6); send_word(16'd7);
        push_result(32'd10); push_result(32'd20); push_result(32'd30); push_status(32'h0);
        for (int i = 0; i < 4; i++) begin
            get_rsp((i == 1) ? 5 : 0, d, st, ok, stable);
            total++;
            if (!ok || d !== exp_d[i] || st !== exp_s[i]) begin
                bad++; $display("FAIL evp rsp[%0d]: got %h/%b ok=%0d want %h/%b", i, d, st, ok, exp_d[i], exp_s[i]);
            end
            if (i == 1) begin
                total++;
                if (!stable) begin bad++; $display("FAIL evp hold: got unstable rsp or extra read want stable 20"); end
            end
        end
        total++; if (rrd_cnt - r0 !== 3) begin bad++; $display("FAIL evp result reads: got %0d want 3", rrd_cnt - r0); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL evp idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_back_pressure;
        int d0, stall_hits;
        logic [31:0] d; logic st; bit ok, stable;
        d0 = dcnt; stall_hits = 0;
        send_req(16'h0103);
        send_word(16'h00A1);
        send_word(16'h00A2);
        data_free_space = '0;
        din = 16'h00A3; din_valid = 1'b1;
        repeat (7) begin
            @(negedge clk);
            if (din_ready || data_wr_en) stall_hits++;
        end
        @(posedge clk);
        #1 data_free_space = 10'd100;
        send_word(16'h00A3);
        send_word(16'h00A4);
        total++; if (stall_hits !== 0) begin bad++; $display("FAIL bp stall: got %0d active cycles want 0", stall_hits); end
        total++; if (dcnt - d0 !== 4)  begin bad++; $display("FAIL bp data count: got %0d want 4", dcnt - d0); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (dlog[(d0 + i) & 63] !== 16'hA1 + 16'(i)) begin
                bad++; $display("FAIL bp data[%0d]: got %h want %h", i, dlog[(d0 + i) & 63], 16'hA1 + 16'(i));
            end
        end
        push_status(32'h0);
        get_rsp(0, d, st, ok, stable);
        total++; if (!ok || d !== 32'h0 || st !== 1'b1) begin bad++; $display("FAIL bp rsp: got %h/%b want 00000000/1", d, st); end
    endtask

    task automatic test_error;
        int r0, c0;
        logic [31:0] d; logic st; bit ok, stable;
        r0 = rrd_cnt;
        send_req(16'h0224);
        for (int i = 0; i < 4; i++) send_word(16'(i + 9));
        push_status(32'h0000_0002);
        get_rsp(0, d, st, ok, stable);
        total++; if (!ok || d !== 32'h2 || st !== 1'b1) begin bad++; $display("FAIL err rsp: got %h/%b want 00000002/1", d, st); end
        total++; if (rrd_cnt - r0 !== 0) begin bad++; $display("FAIL err result reads: got %0d want 0", rrd_cnt - r0); end
        total++; if (busy !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL err idle: got busy=%b rdy=%b want 0/1", busy, req_ready); end
        c0 = ccnt;
        send_req(16'h0500);
        push_status(32'h0);
        get_rsp(0, d, st, ok, stable);
        total++; if (ccnt - c0 !== 1 || clog[c0 & 63] !== 16'h0500) begin bad++; $display("FAIL err next cmd: got n=%0d %h want 1 0500", ccnt - c0, clog[c0 & 63]); end
        total++; if (!ok || d !== 32'h0 || st !== 1'b1) begin bad++; $display("FAIL err next rsp: got %h/%b want 00000000/1", d, st); end
    endtask

    task automatic test_watchdog;
        int k;
        logic [31:0] d; logic st; bit ok, stable;
        send_req(16'h0500);
        k = 0;
        do begin @(negedge clk); k++; end while (!cmd_wr_en && k < 50);
        total++; if (!cmd_wr_en) begin bad++; $display("FAIL wd cmd write: got %b want 1", cmd_wr_en); end
        // 16 silent COLLECT cycles, then the abort token appears on the next sample.
        k = 0;
        do begin @(negedge clk); k++; end while (!rsp_valid && k < 100);
        total++; if (k !== 17) begin bad++; $display("FAIL wd latency: got %0d samples want 17", k); end
        get_rsp(0, d, st, ok, stable);
        total++; if (!ok || d !== 32'hFFFF_FFFF || st !== 1'b1) begin bad++; $display("FAIL wd rsp: got %h/%b want ffffffff/1", d, st); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wd idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid;
        int d0, c0;
        d0 = dcnt; c0 = ccnt;
        send_req(16'h0103);
        send_word(16'h0011);
        send_word(16'h0012);
        din = 16'h0013; din_valid = 1'b1;
        rst = 1'b0;
        #1;
        total++;
        if ({cmd_wr_en, data_wr_en, result_rd_en, status_rd_en} !== 4'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rst_mid enables: got %b busy=%b want 0000 0",
                            {cmd_wr_en, data_wr_en, result_rd_en, status_rd_en}, busy);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        total++; if (req_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid idle: got rdy=%b busy=%b want 1/0", req_ready, busy); end
        repeat (4) @(posedge clk);
        #1 din_valid = 1'b0;
        total++; if (dcnt - d0 !== 2 || ccnt - c0 !== 1) begin bad++; $display("FAIL rst_mid writes: got d=%0d c=%0d want 2/1", dcnt - d0, ccnt - c0); end
    endtask

    initial begin
        test_reset();
        test_stp();
        test_evp();
        test_back_pressure();
        test_error();
        test_watchdog();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
